// File: rtl/id_ex_stage_pkg.sv
// Shared datapath constants, ALU opcodes and the ID/EX control bundle used by
// the decoder, the forwarding unit and the ID/EX stage.
package id_ex_stage_pkg;

   localparam int DATA_W    = 16;
   localparam int REG_W     = 4;
   localparam int ALUOP_W   = 4;
   localparam int DEF_CNT_W = 16;

   localparam logic [ALUOP_W-1:0] ALU_NOP   = 4'h0;
   localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'h1;
   localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'h2;
   localparam logic [ALUOP_W-1:0] ALU_AND   = 4'h3;
   localparam logic [ALUOP_W-1:0] ALU_OR    = 4'h4;
   localparam logic [ALUOP_W-1:0] ALU_XOR   = 4'h5;
   localparam logic [ALUOP_W-1:0] ALU_SLL   = 4'h6;
   localparam logic [ALUOP_W-1:0] ALU_SRL   = 4'h7;
   localparam logic [ALUOP_W-1:0] ALU_SLT   = 4'h8;
   localparam logic [ALUOP_W-1:0] ALU_PASSB = 4'h9;

   typedef struct packed {
      logic               regWrite;
      logic               memRead;
      logic               memWrite;
      logic               swapOp;
      logic [ALUOP_W-1:0] aluOp;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side fields in, EX/forwarding-side registered fields and stall out.
interface id_ex_stage_if
   import id_ex_stage_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);

   // id_valid qualifies every id_* field; stall=1 means IF/ID must hold its
   // contents this cycle; ex_hold=1 freezes EX so the stage keeps its fields.
   logic               id_valid;
   logic [REG_W-1:0]   id_reg_rs;
   logic [REG_W-1:0]   id_reg_rt;
   logic               id_uses_rt;
   logic [DATA_W-1:0]  id_rs_data;
   logic [DATA_W-1:0]  id_rt_data;
   logic [DATA_W-1:0]  id_imm;
   logic [ALUOP_W-1:0] id_alu_op;
   logic               id_reg_write;
   logic               id_mem_read;
   logic               id_mem_write;
   logic               id_swap_op;
   logic               flush;
   logic               ex_hold;

   logic               stall;
   logic               ID_EX_Valid;
   logic [REG_W-1:0]   ID_EX_RegisterRS;
   logic [REG_W-1:0]   ID_EX_RegisterRT;
   logic [DATA_W-1:0]  ID_EX_RSData;
   logic [DATA_W-1:0]  ID_EX_RTData;
   logic [DATA_W-1:0]  ID_EX_Imm;
   logic [ALUOP_W-1:0] ID_EX_ALUOp;
   logic               ID_EX_RegWrite;
   logic               ID_EX_MemRead;
   logic               ID_EX_MemWrite;
   logic               ID_EX_SwapOp;
   logic [CNT_W-1:0]   stall_count;

   modport master (
      output id_valid, id_reg_rs, id_reg_rt, id_uses_rt, id_rs_data, id_rt_data,
             id_imm, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
             id_swap_op, flush, ex_hold,
      input  stall, ID_EX_Valid, ID_EX_RegisterRS, ID_EX_RegisterRT,
             ID_EX_RSData, ID_EX_RTData, ID_EX_Imm, ID_EX_ALUOp,
             ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_SwapOp,
             stall_count
   );

   modport slave (
      input  id_valid, id_reg_rs, id_reg_rt, id_uses_rt, id_rs_data, id_rt_data,
             id_imm, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
             id_swap_op, flush, ex_hold,
      output stall, ID_EX_Valid, ID_EX_RegisterRS, ID_EX_RegisterRT,
             ID_EX_RSData, ID_EX_RTData, ID_EX_Imm, ID_EX_ALUOp,
             ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_SwapOp,
             stall_count
   );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard: a load in EX whose destination RT is read by ID.
module load_use_detect
   import id_ex_stage_pkg::*;
(
   input  logic             exValid,
   input  logic             exMemRead,
   input  logic [REG_W-1:0] exRegRt,
   input  logic             idValid,
   input  logic [REG_W-1:0] idRegRs,
   input  logic [REG_W-1:0] idRegRt,
   input  logic             idUsesRt,
   output logic             hazard
);

   logic rsMatch;
   logic rtMatch;

   // Only RT is a load destination, even for a swap load.
   assign rsMatch = (exRegRt == idRegRs);
   assign rtMatch = idUsesRt & (exRegRt == idRegRt);
   assign hazard  = exValid & exMemRead & idValid & (rsMatch | rtMatch);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling and a
// saturating stall-cycle counter.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
)(
   input  logic         clk,
   input  logic         rst,
   id_ex_stage_if.slave bus
);

   logic               exValid;
   logic [REG_W-1:0]   exRegRs;
   logic [REG_W-1:0]   exRegRt;
   logic [DATA_W-1:0]  exRsData;
   logic [DATA_W-1:0]  exRtData;
   logic [DATA_W-1:0]  exImm;
   id_ex_ctrl_t        exCtrl;
   id_ex_ctrl_t        idCtrl;
   logic [CNT_W-1:0]   stallCount;
   logic               hazard;
   logic               stallNow;

   load_use_detect u_detect (
      .exValid   (exValid),
      .exMemRead (exCtrl.memRead),
      .exRegRt   (exRegRt),
      .idValid   (bus.id_valid),
      .idRegRs   (bus.id_reg_rs),
      .idRegRt   (bus.id_reg_rt),
      .idUsesRt  (bus.id_uses_rt),
      .hazard    (hazard)
   );

   assign stallNow = bus.ex_hold | (hazard & ~bus.flush);

   // An invalid ID slot must not carry live control into EX.
   always_comb begin
      idCtrl = CTRL_BUBBLE;
      if (bus.id_valid) begin
         idCtrl.regWrite = bus.id_reg_write;
         idCtrl.memRead  = bus.id_mem_read;
         idCtrl.memWrite = bus.id_mem_write;
         idCtrl.swapOp   = bus.id_swap_op;
         idCtrl.aluOp    = bus.id_alu_op;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exValid  <= 1'b0;
         exRegRs  <= '0;
         exRegRt  <= '0;
         exRsData <= '0;
         exRtData <= '0;
         exImm    <= '0;
         exCtrl   <= CTRL_BUBBLE;
      end else if (bus.ex_hold) begin
         exValid  <= exValid;
      end else if (bus.flush || hazard) begin
         // Bubble: operand data and immediate are left as they were.
         exValid  <= 1'b0;
         exRegRs  <= '0;
         exRegRt  <= '0;
         exCtrl   <= CTRL_BUBBLE;
      end else begin
         exValid  <= bus.id_valid;
         exRegRs  <= bus.id_reg_rs;
         exRegRt  <= bus.id_reg_rt;
         exRsData <= bus.id_rs_data;
         exRtData <= bus.id_rt_data;
         exImm    <= bus.id_imm;
         exCtrl   <= idCtrl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stallCount <= '0;
      end else if (stallNow && (stallCount != '1)) begin
         stallCount <= stallCount + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.stall            = stallNow;
   assign bus.ID_EX_Valid      = exValid;
   assign bus.ID_EX_RegisterRS = exRegRs;
   assign bus.ID_EX_RegisterRT = exRegRt;
   assign bus.ID_EX_RSData     = exRsData;
   assign bus.ID_EX_RTData     = exRtData;
   assign bus.ID_EX_Imm        = exImm;
   assign bus.ID_EX_ALUOp      = exCtrl.aluOp;
   assign bus.ID_EX_RegWrite   = exCtrl.regWrite;
   assign bus.ID_EX_MemRead    = exCtrl.memRead;
   assign bus.ID_EX_MemWrite   = exCtrl.memWrite;
   assign bus.ID_EX_SwapOp     = exCtrl.swapOp;
   assign bus.stall_count      = stallCount;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage with a 4-bit stall counter.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   localparam int CW  = 4;
   localparam int SAT = 15;

   typedef struct packed {
      logic        rst;
      logic        flush;
      logic        exHold;
      logic        valid;
      logic [3:0]  rs;
      logic [3:0]  rt;
      logic        usesRt;
      logic [15:0] rsData;
      logic [15:0] rtData;
      logic [15:0] imm;
      logic [3:0]  aluOp;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic        swapOp;
   } stim_t;

   typedef struct packed {
      logic        valid;
      logic [3:0]  rs;
      logic [3:0]  rt;
      logic [15:0] rsData;
      logic [15:0] rtData;
      logic [15:0] imm;
      logic [3:0]  aluOp;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic        swapOp;
      logic [3:0]  cnt;
   } state_t;

   typedef struct packed {
      logic   chk;
      logic   chkStall;
      logic   stall;
      state_t st;
   } exp_t;

   logic clk;
   logic rst;
   id_ex_stage_if #(.CNT_W(CW)) bus ();

   id_ex_stage #(.CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   exp_t   expQ[$];
   state_t mdl;
   int     stallCycles;
   logic   mdlKnown;
   int     vectors;
   int     miscompares;

   // ---------------- driver tasks ----------------
   task automatic drive(input stim_t s);
      rst              = s.rst;
      bus.flush        = s.flush;
      bus.ex_hold      = s.exHold;
      bus.id_valid     = s.valid;
      bus.id_reg_rs    = s.rs;
      bus.id_reg_rt    = s.rt;
      bus.id_uses_rt   = s.usesRt;
      bus.id_rs_data   = s.rsData;
      bus.id_rt_data   = s.rtData;
      bus.id_imm       = s.imm;
      bus.id_alu_op    = s.aluOp;
      bus.id_reg_write = s.regWrite;
      bus.id_mem_read  = s.memRead;
      bus.id_mem_write = s.memWrite;
      bus.id_swap_op   = s.swapOp;
   endtask

   task automatic applyCycle(input stim_t s);
      exp_t e;
      logic hz;
      logic st;
      @(posedge clk);
      #1;
      drive(s);
      // A load in EX blocks any ID reader of its destination register.
      hz = mdl.valid && mdl.memRead && s.valid &&
           ((mdl.rt == s.rs) || (s.usesRt && (mdl.rt == s.rt)));
      st = s.exHold || (hz && !s.flush);
      e.chk      = mdlKnown;
      e.chkStall = mdlKnown && !s.rst;
      e.stall    = st;
      e.st       = mdl;
      e.st.cnt   = 4'((stallCycles > SAT) ? SAT : stallCycles);
      expQ.push_back(e);
      if (s.rst) begin
         mdl         = '0;
         stallCycles = 0;
         mdlKnown    = 1'b1;
      end else begin
         if (st) stallCycles++;
         if (!s.exHold) begin
            if (s.flush || hz) begin
               mdl.valid    = 1'b0;
               mdl.rs       = '0;
               mdl.rt       = '0;
               mdl.aluOp    = '0;
               mdl.regWrite = 1'b0;
               mdl.memRead  = 1'b0;
               mdl.memWrite = 1'b0;
               mdl.swapOp   = 1'b0;
            end else begin
               mdl.valid    = s.valid;
               mdl.rs       = s.rs;
               mdl.rt       = s.rt;
               mdl.rsData   = s.rsData;
               mdl.rtData   = s.rtData;
               mdl.imm      = s.imm;
               mdl.aluOp    = s.valid ? s.aluOp : 4'h0;
               mdl.regWrite = s.valid & s.regWrite;
               mdl.memRead  = s.valid & s.memRead;
               mdl.memWrite = s.valid & s.memWrite;
               mdl.swapOp   = s.valid & s.swapOp;
            end
         end
      end
   endtask

   function automatic stim_t randStim(input logic allowRst);
      stim_t s;
      s.rst      = allowRst && ($urandom_range(0, 99) == 0);
      s.flush    = ($urandom_range(0, 9) == 0);
      s.exHold   = ($urandom_range(0, 9) == 0);
      s.valid    = ($urandom_range(0, 3) != 0);
      s.rs       = 4'($urandom_range(0, 3));
      s.rt       = 4'($urandom_range(0, 3));
      s.usesRt   = 1'($urandom_range(0, 1));
      s.rsData   = 16'($urandom);
      s.rtData   = 16'($urandom);
      s.imm      = 16'($urandom);
      s.aluOp    = 4'($urandom_range(0, 15));
      s.regWrite = 1'($urandom_range(0, 1));
      s.memRead  = ($urandom_range(0, 2) == 0);
      s.memWrite = ($urandom_range(0, 4) == 0);
      s.swapOp   = ($urandom_range(0, 5) == 0);
      return s;
   endfunction

   function automatic stim_t loadRt1();
      stim_t s;
      s          = '0;
      s.valid    = 1'b1;
      s.rs       = 4'd6;
      s.rt       = 4'd1;
      s.memRead  = 1'b1;
      s.regWrite = 1'b1;
      s.imm      = 16'h0004;
      return s;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         if (e.chkStall) check("stall", 16'(bus.stall), 16'(e.stall));
         if (e.chk) begin
            check("valid",       16'(bus.ID_EX_Valid),      16'(e.st.valid));
            check("reg_rs",      16'(bus.ID_EX_RegisterRS), 16'(e.st.rs));
            check("reg_rt",      16'(bus.ID_EX_RegisterRT), 16'(e.st.rt));
            check("rs_data",     bus.ID_EX_RSData,          e.st.rsData);
            check("rt_data",     bus.ID_EX_RTData,          e.st.rtData);
            check("imm",         bus.ID_EX_Imm,             e.st.imm);
            check("alu_op",      16'(bus.ID_EX_ALUOp),      16'(e.st.aluOp));
            check("reg_write",   16'(bus.ID_EX_RegWrite),   16'(e.st.regWrite));
            check("mem_read",    16'(bus.ID_EX_MemRead),    16'(e.st.memRead));
            check("mem_write",   16'(bus.ID_EX_MemWrite),   16'(e.st.memWrite));
            check("swap_op",     16'(bus.ID_EX_SwapOp),     16'(e.st.swapOp));
            check("stall_count", 16'(bus.stall_count),      16'(e.st.cnt));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      stim_t s;
      vectors     = 0;
      miscompares = 0;
      mdl         = '0;
      stallCycles = 0;
      mdlKnown    = 1'b0;
      s           = '0;
      s.rst       = 1'b1;
      drive(s);

      // Reset with active inputs.
      repeat (2) begin
         s     = randStim(1'b0);
         s.rst = 1'b1;
         s.exHold = 1'b1;
         applyCycle(s);
      end

      // Pass-through.
      s          = '0;
      s.valid    = 1'b1;
      s.rs       = 4'd2;
      s.rt       = 4'd3;
      s.rsData   = 16'h00AA;
      s.regWrite = 1'b1;
      s.aluOp    = ALU_ADD;
      applyCycle(s);
      applyCycle('0);

      // Load-use on RS: one stall, bubble, then the consumer enters.
      applyCycle(loadRt1());
      s        = '0;
      s.valid  = 1'b1;
      s.rs     = 4'd1;
      s.rt     = 4'd4;
      s.aluOp  = ALU_SUB;
      s.regWrite = 1'b1;
      applyCycle(s);
      applyCycle(s);
      applyCycle('0);

      // RT match without RT use, then a non-load producer.
      applyCycle(loadRt1());
      s        = '0;
      s.valid  = 1'b1;
      s.rs     = 4'd5;
      s.rt     = 4'd1;
      s.usesRt = 1'b0;
      applyCycle(s);
      s          = '0;
      s.valid    = 1'b1;
      s.rt       = 4'd1;
      s.regWrite = 1'b1;
      applyCycle(s);
      s       = '0;
      s.valid = 1'b1;
      s.rs    = 4'd1;
      applyCycle(s);

      // Hazard with flush, then ex_hold with flush.
      applyCycle(loadRt1());
      s       = '0;
      s.valid = 1'b1;
      s.rs    = 4'd1;
      s.flush = 1'b1;
      applyCycle(s);
      applyCycle(loadRt1());
      s.exHold = 1'b1;
      applyCycle(s);
      applyCycle('0);

      // Saturation, then reset in the middle of the hold.
      s     = '0;
      s.rst = 1'b1;
      applyCycle(s);
      s        = '0;
      s.exHold = 1'b1;
      s.valid  = 1'b1;
      repeat (20) applyCycle(s);
      s.rst = 1'b1;
      applyCycle(s);
      s.rst = 1'b0;
      applyCycle(s);

      // Random traffic.
      for (int i = 0; i < 3000; i++) applyCycle(randStim(1'b1));

      applyCycle('0);
      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d pending entries expected 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
